// File: rtl/shift_sequencer.sv
// Iterative barrel-shift sequencer for register-specified ARM shifts of operand 2.
// Moves up to 2^STEP_LOG2 bits per cycle and reports the ARM shifter carry-out.
module shift_sequencer #(
  parameter int STEP_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] val_in,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  shift_amt,
  input  logic        carry_in,
  input  logic        flush,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  localparam logic [5:0] STEP = 6'(1 << STEP_LOG2);

  logic [1:0]  r_state;
  logic [1:0]  r_type;
  logic [31:0] r_acc;
  logic [4:0]  r_rem;
  logic        r_carry;

  logic [5:0]         w_step;
  logic [32:0]        w_lsl;
  logic [32:0]        w_lsr;
  logic signed [32:0] w_asr;
  logic [31:0]        w_ror;
  logic [31:0]        w_nxt_acc;
  logic               w_nxt_c;
  logic [4:0]         w_nxt_rem;

  logic        w_direct;
  logic [31:0] w_dres;
  logic        w_dc;

  // One extra bit on each side of acc catches the last bit shifted out.
  always_comb begin
    w_step    = ({1'b0, r_rem} > STEP) ? STEP : {1'b0, r_rem};
    w_lsl     = {1'b0, r_acc} << w_step;
    w_lsr     = {r_acc, 1'b0} >> w_step;
    w_asr     = $signed({r_acc, 1'b0}) >>> w_step;
    w_ror     = (r_acc >> w_step) | (r_acc << (6'd32 - w_step));
    w_nxt_rem = r_rem - w_step[4:0];
    w_nxt_acc = r_acc;
    w_nxt_c   = r_carry;
    case (r_type)
      T_LSL: begin w_nxt_acc = w_lsl[31:0]; w_nxt_c = w_lsl[32]; end
      T_LSR: begin w_nxt_acc = w_lsr[32:1]; w_nxt_c = w_lsr[0];  end
      T_ASR: begin w_nxt_acc = w_asr[32:1]; w_nxt_c = w_asr[0];  end
      default: begin w_nxt_acc = w_ror; w_nxt_c = w_ror[31]; end
    endcase
  end

  // Cases that need no iteration are resolved straight from the request.
  always_comb begin
    w_direct = 1'b1;
    w_dres   = val_in;
    w_dc     = carry_in;
    if (shift_amt != 8'd0) begin
      case (shift_type)
        T_LSL: begin
          if (shift_amt >= 8'd32) begin
            w_dres = '0;
            w_dc   = (shift_amt == 8'd32) ? val_in[0] : 1'b0;
          end else begin
            w_direct = 1'b0;
          end
        end
        T_LSR: begin
          if (shift_amt >= 8'd32) begin
            w_dres = '0;
            w_dc   = (shift_amt == 8'd32) ? val_in[31] : 1'b0;
          end else begin
            w_direct = 1'b0;
          end
        end
        T_ASR: begin
          if (shift_amt >= 8'd32) begin
            w_dres = {32{val_in[31]}};
            w_dc   = val_in[31];
          end else begin
            w_direct = 1'b0;
          end
        end
        default: begin
          if (shift_amt[4:0] == 5'd0) begin
            w_dres = val_in;
            w_dc   = val_in[31];
          end else begin
            w_direct = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_type  <= T_LSL;
      r_acc   <= '0;
      r_rem   <= '0;
      r_carry <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_type <= shift_type;
            if (w_direct) begin
              r_acc   <= w_dres;
              r_carry <= w_dc;
              r_state <= S_DONE;
            end else begin
              r_acc   <= val_in;
              r_rem   <= shift_amt[4:0];
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_acc   <= w_nxt_acc;
          r_carry <= w_nxt_c;
          r_rem   <= w_nxt_rem;
          if (w_nxt_rem == 5'd0) r_state <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_acc;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a driver queues expected results from an
// arithmetic ARM-shift model, a monitor checks every delivered result and its timing.
module tb_shift_sequencer;

  localparam int STEP_LOG2 = 3;
  localparam int STEP      = 1 << STEP_LOG2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] val_in;
  logic [1:0]  shift_type;
  logic [7:0]  shift_amt;
  logic        carry_in;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        busy;

  shift_sequencer #(.STEP_LOG2(STEP_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .val_in(val_in), .shift_type(shift_type), .shift_amt(shift_amt),
    .carry_in(carry_in), .flush(flush), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .carry_out(carry_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   hold_rr = 1'b1;
  bit   allow_orphan = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ARM shift-by-register rules evaluated with wide arithmetic; lat is the number of
  // edges after the accepting edge until the result is presented.
  function automatic void model(input logic [31:0] v, input logic [1:0] t, input logic [7:0] n,
                                input logic c, output logic [31:0] r, output logic co,
                                output int lat);
    logic [63:0] x;
    int k;
    lat = 0;
    r   = v;
    co  = c;
    if (n != 8'd0) begin
      case (t)
        2'd0: begin
          if (n > 32) begin r = '0; co = 1'b0; end
          else begin
            x = {32'b0, v} << n; r = x[31:0]; co = x[32];
            if (n < 32) lat = (int'(n) + STEP - 1) / STEP;
          end
        end
        2'd1: begin
          if (n > 32) begin r = '0; co = 1'b0; end
          else begin
            x = {v, 32'b0} >> n; r = x[63:32]; co = x[31];
            if (n < 32) lat = (int'(n) + STEP - 1) / STEP;
          end
        end
        2'd2: begin
          k = (n > 32) ? 32 : int'(n);
          x = $signed({v, 32'b0}) >>> k; r = x[63:32]; co = x[31];
          if (n < 32) lat = (int'(n) + STEP - 1) / STEP;
        end
        default: begin
          k = int'(n) % 32;
          if (k == 0) begin r = v; co = v[31]; end
          else begin
            r = (v >> k) | (v << (32 - k)); co = r[31];
            lat = (k + STEP - 1) / STEP;
          end
        end
      endcase
    end
  endfunction

  // Called aligned 2ns after a rising edge; returns aligned the same way after acceptance.
  task automatic send(input logic [31:0] v, input logic [1:0] t, input logic [7:0] n,
                      input logic c, input bit push);
    int w;
    logic [31:0] r;
    logic co;
    int lat;
    exp_t e;
    w = 0;
    while (!req_ready) begin
      @(posedge clk); #2;
      w++;
      if (w > 200) begin fail_now("req_ready_timeout"); return; end
    end
    val_in = v; shift_type = t; shift_amt = n; carry_in = c; req_valid = 1'b1;
    if (push) begin
      model(v, t, n, c, r, co, lat);
      e.res = r; e.c = co; e.due = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(posedge clk); #2;
    req_valid  = 1'b0;
    val_in     = $urandom;
    shift_type = 2'($urandom);
    shift_amt  = 8'($urandom);
    carry_in   = 1'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0) begin
      @(posedge clk); #2;
      w++;
      if (w > 500) begin fail_now("drain_timeout"); sb.delete(); return; end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (!hold_rr) res_ready = ($urandom_range(0, 3) != 0);
  end

  logic        seen = 1'b0;
  logic [31:0] held_r;
  logic        held_c;
  exp_t        cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !res_valid) begin
        seen = 1'b0;
      end else begin
        chk("req_ready_in_done", req_ready, 0);
        chk("busy_in_done", busy, 1);
        if (!seen) begin
          seen = 1'b1; held_r = result; held_c = carry_out;
          if (sb.size() == 0) begin
            if (!allow_orphan) fail_now("unexpected_result");
          end else begin
            chk("latency", cyc, sb[0].due);
          end
        end else begin
          chk("hold_result", result, held_r);
          chk("hold_carry", carry_out, held_c);
        end
        if (res_ready && sb.size() != 0) begin
          cur = sb.pop_front();
          chk("result", result, cur.res);
          chk("carry_out", carry_out, cur.c);
        end
      end
    end
  end

  initial begin
    logic [7:0] n;
    rst_n = 1'b0; req_valid = 1'b0; val_in = '0; shift_type = '0; shift_amt = '0;
    carry_in = 1'b0; flush = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    hold_rr = 1'b0;
    @(posedge clk); #2;

    send(32'h0000_0001, 2'd0, 8'd4,  1'b0, 1);
    send(32'h8000_0000, 2'd1, 8'd20, 1'b1, 1);
    send(32'h8000_0000, 2'd2, 8'd40, 1'b0, 1);
    send(32'h0000_0001, 2'd0, 8'd32, 1'b0, 1);
    send(32'h0000_00F1, 2'd3, 8'd36, 1'b1, 1);
    send(32'h8000_0001, 2'd3, 8'd32, 1'b0, 1);
    send(32'h1234_5678, 2'd1, 8'd0,  1'b1, 1);
    send(32'hF0F0_1234, 2'd0, 8'd33, 1'b1, 1);
    send(32'h8000_0000, 2'd1, 8'd32, 1'b0, 1);
    send(32'hFFFF_FFFF, 2'd1, 8'd200, 1'b1, 1);
    send(32'h8765_4321, 2'd2, 8'd31, 1'b0, 1);
    send(32'h7654_3210, 2'd2, 8'd31, 1'b1, 1);
    send(32'h8000_0003, 2'd3, 8'd31, 1'b0, 1);
    send(32'hC000_0001, 2'd0, 8'd31, 1'b0, 1);
    send(32'h0000_0003, 2'd1, 8'd1,  1'b0, 1);
    send(32'hA5A5_A5A5, 2'd0, 8'd8,  1'b0, 1);
    send(32'hA5A5_A5A5, 2'd1, 8'd9,  1'b0, 1);
    drain();

    for (int i = 0; i < 300; i++) begin
      n = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      send($urandom, 2'($urandom), n, 1'($urandom), 1);
    end
    drain();

    hold_rr = 1'b1; res_ready = 1'b0;
    send(32'h8000_0000, 2'd1, 8'd20, 1'b0, 1);
    for (int w = 0; !res_valid; w++) begin
      if (w > 50) begin fail_now("bp_wait_timeout"); break; end
      @(posedge clk); #2;
    end
    repeat (5) begin
      @(posedge clk); #2;
      chk("bp_req_ready", req_ready, 0);
      chk("bp_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_req_ready", req_ready, 1);
    chk("bp_release_res_valid", res_valid, 0);
    drain();

    send(32'hFFFF_0000, 2'd1, 8'd31, 1'b0, 0);
    @(posedge clk); #2;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush_shift_busy", busy, 0);
    chk("flush_shift_res_valid", res_valid, 0);
    chk("flush_shift_req_ready", req_ready, 1);
    repeat (6) begin
      @(posedge clk); #2;
      chk("flush_no_result", res_valid, 0);
    end

    val_in = 32'h1; shift_type = 2'd0; shift_amt = 8'd0; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", busy, 0);

    allow_orphan = 1'b1; res_ready = 1'b0;
    send(32'h8000_0000, 2'd2, 8'd40, 1'b0, 0);
    chk("flush_done_pre", res_valid, 1);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush_done_res_valid", res_valid, 0);
    chk("flush_done_busy", busy, 0);
    @(posedge clk); #2;
    allow_orphan = 1'b0;

    send(32'h1234_5678, 2'd0, 8'd31, 1'b1, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_res_valid", res_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_carry", carry_out, 0);
    chk("async_rst_req_ready", req_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    hold_rr = 1'b0;
    @(posedge clk); #2;
    send(32'h0000_00F1, 2'd3, 8'd4, 1'b0, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
